instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage of the RV32I core: owns the program counter, issues word reads to instruction memory, and presents one instruction at a time to the decoder with a valid/ready handshake. It sits directly upstream of the decoder, which consumes `Instruction`. It accepts redirects from execute, where branch and jump targets are computed from the decoder's `imm32`. A one-entry holding register absorbs downstream stalls; in-flight fetches are killed on redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP`, default 32'h0000_0013 (`addi x0,x0,0`): `Instruction` value while empty or in reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low (0 = reset).
- `imem_req`  out  1  single-cycle read request to instruction memory.
- `imem_addr`  out  32  word-aligned read address; valid while `imem_req`=1.
- `imem_rvalid`  in  1  read data valid, at least one cycle after the request.
- `imem_rdata`  in  32  instruction word returned.
- `inst_valid`  out  1  `Instruction`/`inst_pc` hold a live instruction.
- `inst_ready`  in  1  decoder accepts the instruction this cycle.
- `Instruction`  out  32  instruction to the decoder.
- `inst_pc`  out  32  address of `Instruction`.
- `redirect`  in  1  taken branch or jump.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored and forced to 00.

## Operation
- FSM states: IDLE, FETCH, WAIT, FULL.
- IDLE: entered on reset. On the first rising edge with `reset`=1, go to FETCH.
- FETCH: `imem_req`=1 and `imem_addr`=pc for exactly this cycle. Next state is WAIT.
- WAIT: on `imem_rvalid`=1:
  - `drop`=0: capture `imem_rdata` into `Instruction` and pc into `inst_pc`, then go to FULL.
  - `drop`=1: discard the data, clear `drop`, go to FETCH.
- FULL: `inst_valid`=1. When `inst_valid & inst_ready`: pc <= pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), go to FETCH.
- Redirect (any state except IDLE): pc <= {redirect_pc[31:2],2'b00}.
  - FETCH: the request still issues with the old pc; set `drop`; go to WAIT.
  - WAIT without rvalid: set `drop`; stay in WAIT.
  - WAIT with rvalid in the same cycle: discard the data; go to FETCH.
  - FULL: invalidate the buffer (`inst_valid`=0 next cycle); go to FETCH. Redirect beats `inst_ready` in the same cycle: no pc+4, target wins.
- Back-to-back redirects: the last one wins; `drop` is a single bit because only one request is ever outstanding.
- `imem_rvalid` in IDLE, FETCH or FULL is ignored.
- Outputs in FULL stay stable until handshake or redirect.

## Timing
- Reset values: pc=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `Instruction`=`NOP`, `inst_pc`=`RESET_PC`, `drop`=0, state=IDLE.
- Reset assertion mid-operation clears all state immediately. An outstanding memory response arriving after reset is ignored because the state is IDLE.
- Zero-wait memory (rvalid one cycle after req): req at cycle N, `inst_valid` at N+2. With continuous `inst_ready`, throughput is one instruction per 3 cycles.
- Redirect at cycle N in FULL: req to the target at N+1, earliest `inst_valid` at N+3.
- `imem_addr` is registered (driven from pc); no combinational path from `inst_ready` or `redirect` to `imem_req`/`imem_addr`.

## Structure
- Shared package `cpu_pkg` holds:
  - the state enum `fetch_state_t` (IDLE, FETCH, WAIT, FULL);
  - the `NOP` constant;
  - the default `RESET_PC`;
  - `XLEN`=32.
- Single module; no sub-module needed. PC register, FSM and holding register fit in about 150–200 lines.

## Test plan
- Reset/startup: hold `reset`=0 for 3 cycles, release; memory returns 0x00500093 one cycle after req. Required: first req at addr 0x0 the cycle after release, then `inst_valid`=1, `Instruction`=0x00500093, `inst_pc`=0x0.
- Stall: `inst_ready`=0 for 5 cycles while FULL. Required: `Instruction`/`inst_pc` constant and no new `imem_req`. Raising ready gives the next req at 0x4.
- Redirect in WAIT: req 0x8, assert `redirect` with `redirect_pc`=0x103 before rvalid. Required: the response is dropped, the next req is at 0x100, and `inst_valid` never shows the 0x8 word.
- Redirect and `inst_ready` in the same cycle in FULL at pc 0x20 with target 0x40. Required: next req at 0x40, not 0x24.
- Wrap: `RESET_PC`=0xFFFF_FFFC, accept one instruction. Required: next req at 0x0000_0000.
- Reset mid-WAIT: assert `reset` low while a request is outstanding, deliver rvalid during reset. Required: all outputs at reset values, data ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared across the RV32I core.
package cpu_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   typedef enum logic [1:0] {IDLE, FETCH, WAIT, FULL} fetch_state_t;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage with the PC, one outstanding imem read and a one-entry instruction buffer.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [XLEN-1:0] NOP      = NOP_INSN
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] Instruction,
   output logic [XLEN-1:0] inst_pc,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc
);
   fetch_state_t    state_q;
   logic [XLEN-1:0] pc_q, instr_q, inst_pc_q, target_d;
   logic            req_q, valid_q, drop_q;

   assign target_d    = redirect_pc & ~XLEN'(3);
   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign inst_valid  = valid_q;
   assign Instruction = instr_q;
   assign inst_pc     = inst_pc_q;

   // pc_q always holds the address of the next instruction to hand to the decoder
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         req_q     <= 1'b0;
         valid_q   <= 1'b0;
         instr_q   <= NOP;
         inst_pc_q <= RESET_PC;
         drop_q    <= 1'b0;
      end else begin
         req_q <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q <= FETCH;
               req_q   <= 1'b1;
            end
            FETCH: begin
               state_q <= WAIT;
               if (redirect) begin
                  pc_q   <= target_d;
                  drop_q <= 1'b1;
               end
            end
            WAIT: begin
               if (redirect) pc_q <= target_d;
               if (imem_rvalid) begin
                  drop_q <= 1'b0;
                  if (drop_q || redirect) begin
                     state_q <= FETCH;
                     req_q   <= 1'b1;
                  end else begin
                     state_q   <= FULL;
                     valid_q   <= 1'b1;
                     instr_q   <= imem_rdata;
                     inst_pc_q <= pc_q;
                  end
               end else if (redirect) drop_q <= 1'b1;
            end
            FULL: begin
               if (redirect || inst_ready) begin
                  pc_q    <= redirect ? target_d : pc_q + XLEN'(4);
                  state_q <= FETCH;
                  req_q   <= 1'b1;
                  valid_q <= 1'b0;
                  instr_q <= NOP;
               end
            end
         endcase
      end
   end
endmodule
